demux4_stream: RTL and testbench

- 1-to-4 registered stream demultiplexer; the inverse of the 4:1 datapath mux.
- Accepts one WIDTH-bit word plus a 2-bit destination select over a valid/ready handshake.
- Holds the word in a single output register and presents it to exactly one of four consumer lanes.
- Sits between a single producer (e.g. a writeback/forwarding source) and four consumers; sustains full throughput, one word per clk.

---
 rtl/demux4_pkg.sv | 17 +
 rtl/demux4_stream_dec2to4.sv | 22 ++
 rtl/demux4_stream.sv | 145 ++++++++++++++
 tb/tb_demux4_stream.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// demux4_pkg: shared types and constants for the demux4_stream block.
//   NUM_LANES      - number of consumer lanes
//   lane_sel_t     - 2-bit lane index
//   demux4_state_t - holding-register occupancy state
package demux4_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } demux4_state_t;

endpackage : demux4_pkg

// File: rtl/demux4_stream_dec2to4.sv
// dec2to4: combinational 2-to-4 one-hot decoder with enable.
// Ports:
//   en_i       - when low, all outputs are zero
//   sel_i      - lane index to decode
//   onehot_c_o - one-hot lane vector (combinational)
module dec2to4
  import demux4_pkg::*;
(
  input  logic                 en_i,
  input  lane_sel_t            sel_i,
  output logic [NUM_LANES-1:0] onehot_c_o
);

  // One-hot decode gated by enable
  always_comb begin
    onehot_c_o = '0;
    if (en_i) begin
      onehot_c_o[sel_i] = 1'b1;
    end
  end

endmodule : dec2to4

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 registered stream demultiplexer.
// A single holding register captures one word plus its destination lane and
// presents it to exactly one of four consumer lanes. Draining and refilling
// can happen in the same cycle, so full throughput (one word/clk) is kept.
// Optional build macro: DEMUX4_STATS_EN adds per-lane transfer counters on
// the lane_cnt port.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   in_valid   - producer has a word
//   in_ready   - block accepts a word this cycle (combinational from out_ready)
//   in_data    - word to route
//   in_sel     - destination lane 0..3
//   out_valid  - one-hot lane valid for the held word
//   out_ready  - per-lane consumer ready
//   out_data   - held word, shared by all lanes
//   out_sel    - lane of the held word
//   busy       - holding register is occupied
//   lane_cnt   - per-lane transfer counters (DEMUX4_STATS_EN only)
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_sel,
  output logic                 busy
`ifdef DEMUX4_STATS_EN
  ,
  output logic [3:0][CNT_W-1:0] lane_cnt
`endif
);

  // Parameter sanity at elaboration
  if (WIDTH == 0 || CNT_W == 0) begin : g_bad_param
    $error("demux4_stream: WIDTH and CNT_W must be non-zero");
  end

  demux4_state_t    state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  lane_sel_t        sel_q, sel_d;

  logic in_fire;
  logic out_fire;
  logic full;

  assign full = (state_q == FULL);

  // Lane valid is a pure decode of registered state: no in_* -> out_* path
  dec2to4 u_valid_dec (
    .en_i       (full),
    .sel_i      (sel_q),
    .onehot_c_o (out_valid)
  );

  // Only the addressed lane's ready can drain the register
  assign out_fire = |(out_valid & out_ready);
  assign in_ready = (state_q == EMPTY) | out_ready[sel_q];
  assign in_fire  = in_valid & in_ready;

  assign out_data = data_q;
  assign out_sel  = sel_q;
  assign busy     = full;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state: capture on in_fire, drop to EMPTY on a drain without refill
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          data_d  = in_data;
          sel_d   = lane_sel_t'(in_sel);
        end
      end
      FULL: begin
        if (out_fire) begin
          if (in_fire) begin
            data_d = in_data;
            sel_d  = lane_sel_t'(in_sel);
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef DEMUX4_STATS_EN
  logic [NUM_LANES-1:0]            cnt_inc;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Same decoder steers the single per-cycle increment
  dec2to4 u_cnt_dec (
    .en_i       (out_fire),
    .sel_i      (sel_q),
    .onehot_c_o (cnt_inc)
  );

  // Counters wrap naturally at all-ones
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (cnt_inc[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lane_cnt = cnt_q;
`endif

endmodule : demux4_stream

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed bench for demux4_stream with a scoreboard queue.
// Accepted words are pushed when the model sees an input handshake and popped
// and compared when the model sees the addressed lane take the word.
module tb_demux4_stream;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             busy;
`ifdef DEMUX4_STATS_EN
  logic [3:0][CNT_W-1:0] lane_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ent_t               sb[$];
  logic [CNT_W-1:0]   exp_cnt [4];
  int                 in_fires;

  demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
`ifdef DEMUX4_STATS_EN
    ,
    .lane_cnt  (lane_cnt)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] v;
    v = 4'b0000;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic chk_cnt(input string tag);
`ifdef DEMUX4_STATS_EN
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_lane_cnt%0d", tag, k), 64'(lane_cnt[k]), 64'(exp_cnt[k]));
    end
`else
    if (tag.len() < 0) $display("unused");
`endif
  endtask

  // One clock: check at negedge against the model, advance model, step past posedge
  task automatic tick(input string tag);
    logic exp_full;
    logic exp_ready;
    logic m_out_fire;
    ent_t front;
    ent_t popped;
    @(negedge clk);
    exp_full  = (sb.size() != 0);
    front     = exp_full ? sb[0] : '0;
    exp_ready = !exp_full || out_ready[front.sel];
    m_out_fire = exp_full && out_ready[front.sel];
    chk({tag, "_busy"},      64'(busy),      64'(exp_full));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(exp_ready));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(exp_full ? onehot(front.sel) : 4'b0000));
    if (exp_full) begin
      chk({tag, "_out_sel"},  64'(out_sel),  64'(front.sel));
      chk({tag, "_out_data"}, 64'(out_data), 64'(front.data));
    end
    chk_cnt(tag);
    if (m_out_fire) begin
      popped = sb.pop_front();
      exp_cnt[popped.sel] = exp_cnt[popped.sel] + CNT_W'(1);
    end
    if (in_valid && exp_ready) begin
      sb.push_back('{sel: in_sel, data: in_data});
      in_fires++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
    in_fires  = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_A5A5;
    in_sel    = 2'd1;
    out_ready = 4'b1111;

    // Reset held for 15 ns with a pending input
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_busy",      64'(busy),      64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_sel",   64'(out_sel),   64'h0);
    chk_cnt("rst");
    #3;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;

    // Single route to lane 2
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    in_sel    = 2'd2;
    out_ready = 4'b0100;
    tick("single_acc");
    in_valid  = 1'b0;
    chk("single_visible_valid", 64'(out_valid), 64'h4);
    chk("single_visible_data",  64'(out_data),  64'hDEADBEEF);
    tick("single_drain");
    tick("single_empty");

    // Back-pressure on lane 1; a second offered word must not be taken
    in_valid  = 1'b1;
    in_data   = 32'h0000_0011;
    in_sel    = 2'd1;
    out_ready = 4'b1101;
    tick("bp_acc");
    in_data   = 32'h0000_0BAD;
    in_sel    = 2'd3;
    for (int i = 0; i < 3; i++) tick("bp_stall");
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    tick("bp_drain");
    tick("bp_empty");

    // Held word targets lane 3; other lanes' ready is ignored
    in_valid  = 1'b1;
    in_data   = 32'h0000_0033;
    in_sel    = 2'd3;
    out_ready = 4'b0111;
    tick("wl_acc");
    in_valid  = 1'b0;
    tick("wl_stall0");
    tick("wl_stall1");
    out_ready = 4'b1000;
    tick("wl_drain");
    tick("wl_empty");

    // Back-to-back streaming, all lanes ready
    in_fires  = 0;
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i % 4);
      in_data  = 32'(i + 1);
      tick("stream");
    end
    in_valid = 1'b0;
    tick("stream_tail");
    tick("stream_empty");
    chk("stream_accepts", 64'(in_fires), 64'd8);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-transfer with lane 0 stalled
    in_valid  = 1'b1;
    in_data   = 32'h0000_0055;
    in_sel    = 2'd0;
    out_ready = 4'b1110;
    tick("mid_acc");
    in_valid  = 1'b0;
    tick("mid_stall");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_busy",      64'(busy),      64'h0);
    chk("mid_rst_out_data",  64'(out_data),  64'h0);
    sb.delete();
    for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
    chk_cnt("mid_rst");
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    tick("after_rst0");
    tick("after_rst1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_demux4_stream
